// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the three-line convolution line-buffer sequencer.
package linebuf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned NUM_LINES = 3;

    // Advance a line-RAM selector 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rot3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/lb_raster_cnt.sv
// Raster column/row counter: column wraps at width-1 and bumps the row.
// Flags are combinational views of the current position.
module lb_raster_cnt #(
    parameter int unsigned AW = 11,
    parameter int unsigned HW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          adv,
    input  logic [AW-1:0] width,
    input  logic [HW-1:0] height,
    output logic [AW-1:0] col,
    output logic [HW-1:0] row,
    output logic          eol,
    output logic          eof,
    output logic          row_wrap
);

    assign eol      = (col == width - AW'(1));
    assign eof      = eol && (row == height - HW'(1));
    assign row_wrap = adv && eol;

    // Position register: clear wins, otherwise step on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (eol) begin
                col <= '0;
                row <= row + HW'(1);
            end else begin
                col <= col + AW'(1);
            end
        end
    end

endmodule

// File: rtl/linebuf_sched.sv
// Line-buffer scheduler: writes incoming rows into three rotating line RAMs
// and, from row 2 on, reads the two older rows at the incoming column to emit
// aligned top/mid/bot window columns one cycle after each accepted pixel.
// Optional feature macro: LB_ABORT_EN adds an 'abort' input that forces IDLE.
module linebuf_sched
    import linebuf_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 11,
    parameter int unsigned HW = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef LB_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      start,
    input  logic [AW-1:0]             fm_width,
    input  logic [HW-1:0]             fm_height,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic [NUM_LINES-1:0]      ram_wen,
    output logic [AW-1:0]             ram_waddr,
    output logic [DW-1:0]             ram_wdata,
    output logic [NUM_LINES-1:0]      ram_ren,
    output logic [AW-1:0]             ram_raddr,
    input  logic [NUM_LINES*DW-1:0]   ram_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_top,
    output logic [DW-1:0]             out_mid,
    output logic [DW-1:0]             out_bot,
    output logic [AW-1:0]             out_col,
    output logic                      out_eol,
    output logic                      out_eof
);

    state_t               state, state_nxt;
    logic [AW-1:0]        w_q;
    logic [HW-1:0]        h_q;
    logic [1:0]           wr_sel;
    logic [1:0]           top_sel_q, mid_sel_q;
    logic                 fin_q;
    logic                 ov_q;
    logic                 cfg_err_q;
    logic [DW-1:0]        bot_q;
    logic [AW-1:0]        col_q;
    logic                 eol_q, eof_q;

    logic                 abort_w;
    logic                 dims_ok, start_ok, rdy, acc, cnt_clear;
    logic [AW-1:0]        cnt_col;
    logic [HW-1:0]        cnt_row;
    logic                 cnt_eol, cnt_eof, cnt_wrap;
    logic [NUM_LINES-1:0] wen_oh;

`ifdef LB_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign dims_ok   = (fm_width >= AW'(3)) && (fm_height >= HW'(3));
    assign start_ok  = (state == IDLE) && start && dims_ok && !abort_w;
    assign cnt_clear = abort_w || start_ok || (state == DONE);

    lb_raster_cnt #(
        .AW (AW),
        .HW (HW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .adv      (acc),
        .width    (w_q),
        .height   (h_q),
        .col      (cnt_col),
        .row      (cnt_row),
        .eol      (cnt_eol),
        .eof      (cnt_eof),
        .row_wrap (cnt_wrap)
    );

    // Input acceptance: free-running while filling, gated by the output slot while running.
    always_comb begin
        rdy = 1'b0;
        if (!abort_w) begin
            case (state)
                FILL:    rdy = 1'b1;
                RUN:     rdy = (!ov_q || out_ready) && !fin_q;
                default: rdy = 1'b0;
            endcase
        end
        acc = in_valid && rdy;
    end

    // One-hot write lane for the row currently being written.
    always_comb begin
        case (wr_sel)
            2'd0:    wen_oh = 3'b001;
            2'd1:    wen_oh = 3'b010;
            default: wen_oh = 3'b100;
        endcase
    end

    // RAM ports: write current row, read the other two rows at the same column.
    always_comb begin
        ram_wen   = acc ? wen_oh : '0;
        ram_ren   = (acc && (state == RUN)) ? ~wen_oh : '0;
        ram_waddr = cnt_col;
        ram_raddr = cnt_col;
        ram_wdata = in_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = FILL;
            FILL: if (cnt_wrap && (cnt_row == HW'(1))) state_nxt = RUN;
            RUN:  if (ov_q && out_ready && eof_q) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_w) state_nxt = IDLE;
    end

    // Frame bookkeeping and the registered half of the output column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q       <= '0;
            h_q       <= '0;
            wr_sel    <= '0;
            fin_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            ov_q      <= 1'b0;
            bot_q     <= '0;
            col_q     <= '0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            top_sel_q <= '0;
            mid_sel_q <= '0;
        end else if (abort_w) begin
            wr_sel    <= '0;
            fin_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            cfg_err_q <= (state == IDLE) && start && !dims_ok;
            if (start_ok) begin
                w_q    <= fm_width;
                h_q    <= fm_height;
                wr_sel <= '0;
                fin_q  <= 1'b0;
            end
            if (cnt_wrap) wr_sel <= rot3(wr_sel);
            if (acc && cnt_eof) fin_q <= 1'b1;
            if (state == DONE) begin
                wr_sel <= '0;
                fin_q  <= 1'b0;
            end
            if (acc && (state == RUN)) begin
                ov_q      <= 1'b1;
                bot_q     <= in_data;
                col_q     <= cnt_col;
                eol_q     <= cnt_eol;
                eof_q     <= cnt_eof;
                top_sel_q <= rot3(wr_sel);
                mid_sel_q <= rot3(rot3(wr_sel));
            end else if (out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    // Older rows come straight from the RAM read port, which holds while stalled.
    always_comb begin
        out_top = '0;
        out_mid = '0;
        if (ov_q) begin
            case (top_sel_q)
                2'd0:    out_top = ram_rdata[DW-1:0];
                2'd1:    out_top = ram_rdata[2*DW-1:DW];
                default: out_top = ram_rdata[3*DW-1:2*DW];
            endcase
            case (mid_sel_q)
                2'd0:    out_mid = ram_rdata[DW-1:0];
                2'd1:    out_mid = ram_rdata[2*DW-1:DW];
                default: out_mid = ram_rdata[3*DW-1:2*DW];
            endcase
        end
    end

    assign out_valid = ov_q;
    assign out_bot   = bot_q;
    assign out_col   = col_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign in_ready  = rdy;
    assign busy      = (state == FILL) || (state == RUN);
    assign done      = (state == DONE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_linebuf_sched.sv
// Directed bench for linebuf_sched with a behavioural three-line RAM model.
// Pixel value for row r, column c is r*16+c.
module tb_linebuf_sched;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 11;
    localparam int unsigned HW = 11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
`ifdef LB_ABORT_EN
    logic            abort = 1'b0;
`endif
    logic            start = 1'b0;
    logic [AW-1:0]   fm_width = '0;
    logic [HW-1:0]   fm_height = '0;
    logic            busy, done, cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic [2:0]      ram_wen, ram_ren;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]   ram_wdata;
    logic [3*DW-1:0] ram_rdata;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_top, out_mid, out_bot;
    logic [AW-1:0]   out_col;
    logic            out_eol, out_eof;

    int checks = 0;
    int failures = 0;
    logic [23:0] first_col, last_col;
    logic        saw_cfg_err;

    logic [DW-1:0] mem [3][2048];
    logic [DW-1:0] rq  [3];

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_wen[k]) mem[k][ram_waddr] <= ram_wdata;
            if (ram_ren[k]) rq[k] <= mem[k][ram_raddr];
        end
    end
    initial for (int k = 0; k < 3; k++) rq[k] = '0;
    assign ram_rdata = {rq[2], rq[1], rq[0]};

    linebuf_sched #(.DW(DW), .AW(AW), .HW(HW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef LB_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .fm_width  (fm_width),
        .fm_height (fm_height),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_top   (out_top),
        .out_mid   (out_mid),
        .out_bot   (out_bot),
        .out_col   (out_col),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        start     = 1'b1;
        fm_width  = AW'(w);
        fm_height = HW'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams one frame and checks every write, every emitted column, stalls and done.
    task automatic run_frame(input int w, input int h, input int stall_at, input int stall_len,
                             input int cut_at, input int inject_at, output int n_out);
        int pix, k, r, c, budget;
        logic got_done, eof_hs_prev, prev_stall;
        logic [37:0] prev_snap;
        logic [2:0]  exp_wen, exp_ren;
        logic [36:0] exp_col;
        pix = 0; k = 0; got_done = 1'b0; eof_hs_prev = 1'b0; prev_stall = 1'b0;
        prev_snap = '0; saw_cfg_err = 1'b0; n_out = 0;
        budget = w * h * 2 + 40;
        for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == inject_at);
            if (cyc == inject_at) begin
                fm_width  = AW'(6);
                fm_height = HW'(5);
            end
            if (pix < w * h) begin
                in_valid = 1'b1;
                in_data  = DW'((pix / w) * 16 + pix % w);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            if (cyc == cut_at) begin
                in_valid = 1'b0;
                in_data  = '0;
                n_out = k;
                return;
            end
            if (cfg_err) saw_cfg_err = 1'b1;
            if (done) begin
                checks++;
                if (!eof_hs_prev || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_timing got eof_prev=%0b busy=%0b exp eof_prev=1 busy=0", eof_hs_prev, busy);
                end
                got_done = 1'b1;
            end
            eof_hs_prev = 1'b0;
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_top, out_mid, out_bot, out_col, out_eol, out_eof} !== prev_snap) begin
                    failures++;
                    $display("FAIL stall_hold got=%h exp=%h", {out_valid, out_top, out_mid, out_bot, out_col, out_eol, out_eof}, prev_snap);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if ({in_ready, ram_wen, ram_ren} !== 7'd0) begin
                    failures++;
                    $display("FAIL stall_enables got in_ready=%0b wen=%b ren=%b exp all 0", in_ready, ram_wen, ram_ren);
                end
            end
            if (in_valid && in_ready) begin
                r = pix / w;
                c = pix % w;
                exp_wen = 3'b001 << (r % 3);
                exp_ren = (r >= 2) ? (~exp_wen & 3'b111) : 3'b000;
                checks++;
                if ({ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata} !== {exp_wen, exp_ren, AW'(c), AW'(c), in_data}) begin
                    failures++;
                    $display("FAIL write_port pix=%0d got wen=%b ren=%b wa=%0d ra=%0d wd=%h exp wen=%b ren=%b wa=%0d ra=%0d wd=%h",
                             pix, ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata, exp_wen, exp_ren, c, c, in_data);
                end
                pix++;
            end
            if (out_valid && out_ready) begin
                r = 2 + k / w;
                c = k % w;
                exp_col = {DW'((r - 2) * 16 + c), DW'((r - 1) * 16 + c), DW'(r * 16 + c), AW'(c),
                           (c == w - 1), (r == h - 1) && (c == w - 1)};
                checks++;
                if ({out_top, out_mid, out_bot, out_col, out_eol, out_eof} !== exp_col) begin
                    failures++;
                    $display("FAIL column k=%0d got=%h exp=%h", k, {out_top, out_mid, out_bot, out_col, out_eol, out_eof}, exp_col);
                end
                if (k == 0) first_col = {out_top, out_mid, out_bot};
                last_col = {out_top, out_mid, out_bot};
                eof_hs_prev = out_eof;
                k++;
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = {out_valid, out_top, out_mid, out_bot, out_col, out_eol, out_eof};
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b0;
        n_out = k;
        if (!got_done) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout got outputs=%0d exp done within %0d cycles", k, budget);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({busy, done, cfg_err, in_ready, ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
             out_valid, out_top, out_mid, out_bot, out_col, out_eol, out_eof} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b in_ready=%0b wen=%b ren=%b out_valid=%0b exp all 0",
                     busy, in_ready, ram_wen, ram_ren, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, ram_wen} !== 5'd0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%0b in_ready=%0b wen=%b exp 0", busy, in_ready, ram_wen);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_frame_4x4;
        int n;
        do_start(4, 4);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%0b exp=1", busy);
        end
        run_frame(4, 4, -1, 0, -1, -1, n);
        #1;
        checks++;
        if (n != 8) begin failures++; $display("FAIL count_4x4 got=%0d exp=8", n); end
        checks++;
        if (first_col !== 24'h001020) begin failures++; $display("FAIL first_4x4 got=%h exp=001020", first_col); end
        checks++;
        if (last_col !== 24'h132333) begin failures++; $display("FAIL last_4x4 got=%h exp=132333", last_col); end
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("FAIL done_single_pulse got done=%0b busy=%0b exp 0 0", done, busy); end
    endtask

    task automatic test_rotation_5x6;
        int n;
        do_start(5, 6);
        run_frame(5, 6, -1, 0, -1, -1, n);
        checks++;
        if (n != 20) begin failures++; $display("FAIL count_5x6 got=%0d exp=20", n); end
        checks++;
        if (last_col !== 24'h344454) begin failures++; $display("FAIL last_5x6 got=%h exp=344454", last_col); end
    endtask

    task automatic test_backpressure;
        int n;
        do_start(8, 3);
        run_frame(8, 3, 20, 3, -1, -1, n);
        checks++;
        if (n != 8) begin failures++; $display("FAIL count_bp got=%0d exp=8", n); end
    endtask

    task automatic test_cfg_err;
        logic bad;
        for (int t = 0; t < 2; t++) begin
            do_start((t == 0) ? 2 : 4, (t == 0) ? 4 : 2);
            #1;
            checks++;
            if ({cfg_err, busy, ram_wen, ram_ren} !== {1'b1, 1'b0, 6'd0}) begin
                failures++;
                $display("FAIL cfg_err_pulse t=%0d got cfg_err=%0b busy=%0b wen=%b ren=%b exp 1 0 0 0", t, cfg_err, busy, ram_wen, ram_ren);
            end
            @(negedge clk);
            #1;
            bad = cfg_err | busy;
            checks++;
            if (bad !== 1'b0) begin
                failures++;
                $display("FAIL cfg_err_clear t=%0d got cfg_err=%0b busy=%0b exp 0 0", t, cfg_err, busy);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        do_start(4, 3);
        run_frame(4, 3, -1, 0, -1, 3, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL count_start_busy got=%0d exp=4", n); end
        checks++;
        if (saw_cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_while_busy got=%0b exp=0", saw_cfg_err); end
    endtask

    task automatic test_async_reset;
        int n;
        do_start(4, 5);
        run_frame(4, 5, -1, 0, 10, -1, n);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%0b exp=1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cfg_err, in_ready, ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
             out_valid, out_top, out_mid, out_bot, out_col, out_eol, out_eof} !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%0b in_ready=%0b out_valid=%0b col=%0d bot=%h exp all 0",
                     busy, in_ready, out_valid, out_col, out_bot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(4, 4);
        run_frame(4, 4, -1, 0, -1, -1, n);
        checks++;
        if (n != 8 || first_col !== 24'h001020) begin
            failures++;
            $display("FAIL restart_after_reset got n=%0d first=%h exp n=8 first=001020", n, first_col);
        end
    endtask

`ifdef LB_ABORT_EN
    task automatic test_abort;
        int n;
        logic seen_done;
        do_start(4, 6);
        run_frame(4, 6, -1, 0, 13, -1, n);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hAA;
        #1;
        checks++;
        if ({busy, done, out_valid, in_ready, ram_wen, ram_ren} !== 10'd0) begin
            failures++;
            $display("FAIL abort_idle got busy=%0b done=%0b ov=%0b rdy=%0b wen=%b ren=%b exp all 0",
                     busy, done, out_valid, in_ready, ram_wen, ram_ren);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0b exp=0", seen_done); end
        do_start(4, 4);
        run_frame(4, 4, -1, 0, -1, -1, n);
        checks++;
        if (n != 8 || last_col !== 24'h132333) begin
            failures++;
            $display("FAIL frame_after_abort got n=%0d last=%h exp n=8 last=132333", n, last_col);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_4x4();
        test_rotation_5x6();
        test_backpressure();
        test_cfg_err();
        test_start_while_busy();
        test_async_reset();
`ifdef LB_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/linebuf_sched.md
Name: linebuf_sched

Overview:
- Sequencer for the three rotating line RAMs feeding the 3x3 convolution window.
- Accepts a raster pixel stream and writes each row into the RAMs round-robin.
- Once two rows are buffered, it reads the two older rows at the same column as each incoming pixel and emits aligned 3-pixel columns (top/mid/bot) downstream.
- Owns all RAM enables and addresses, row rotation and frame start/stop sequencing.

Parameters:
- DW, 8, pixel data width
- AW, 11, RAM address width; fm_width max 2^AW-1
- HW, 11, height counter width; fm_height max 2^HW-1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches fm_width/fm_height and begins a frame
- fm_width  in  AW  pixels per row
- fm_height  in  HW  rows per frame
- busy  out  1  high from accepted start to frame end
- done  out  1  one-cycle pulse after last column emitted
- cfg_err  out  1  one-cycle pulse on rejected start
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid&in_ready
- in_data  in  DW  input pixel
- ram_wen  out  3  one-hot write enable
- ram_waddr  out  AW  write address (column)
- ram_wdata  out  DW  write data (= in_data)
- ram_ren  out  3  read enables
- ram_raddr  out  AW  read address (column)
- ram_rdata  in  3*DW  read data; RAM k at [(k+1)*DW-1:k*DW]; 1-cycle latency, held while ren low
- out_valid  out  1  column valid
- out_ready  in  1  downstream accept
- out_top, out_mid, out_bot  out  DW each  window column, oldest row first
- out_col  out  AW  column index of emitted column
- out_eol  out  1  last column of a row
- out_eof  out  1  last column of frame

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready=0; wr_sel=0, counters 0.
- States:
  - IDLE: start with fm_width>=3 and fm_height>=3 -> latch dims, go FILL; otherwise cfg_err pulse, stay IDLE. start while busy is ignored.
  - FILL: rows 0,1. in_ready=1. Each accepted pixel: ram_wen[wr_sel]=1, ram_waddr=col. No output.
  - RUN: rows 2..H-1. in_ready = !out_valid | out_ready. Each accepted pixel, same cycle: write ram[wr_sel] at col; ren on top_sel=(wr_sel+1)%3 and mid_sel=(wr_sel+2)%3; raddr=col. in_data, sels, col, eol, eof are registered. Next cycle out_valid=1 with out_top=rdata[top_sel], out_mid=rdata[mid_sel], out_bot=registered pixel.
  - DONE: entered when the eof column is handshaken; done pulse, busy=0, back to IDLE.
- Column/row counters:
  - col wraps at fm_width-1; on wrap, row++ and wr_sel rotates 0->1->2->0.
  - FILL->RUN on wrap of row 1.
  - Last accepted pixel (row H-1, col W-1) drops in_ready until DONE.
- Backpressure: out_valid && !out_ready holds all outputs stable; no ren/wen asserted; RAM data held.
- Write and read hit different RAMs at the same address, so there is no collision.
- Latency: pixel accept -> column out_valid, 1 cycle. Throughput 1 column/cycle with out_ready=1.
- Output count per frame: (H-2)*W columns.

Optional Feature:
- Macro LB_ABORT_EN.
- Defined: adds input port abort (1 bit). abort high in any state forces IDLE next cycle: out_valid=0, wen/ren=0, busy=0, counters and wr_sel cleared, no done pulse. abort has priority over start in the same cycle.
- Undefined: port absent; a frame always runs to completion.

Decomposition:
- Package linebuf_pkg:
  - state enum {IDLE, FILL, RUN, DONE}
  - constant NUM_LINES=3
  - function rot3 (mod-3 increment)
- One natural sub-module, lb_raster_cnt: col/row counters with wrap, eol/eof/row-wrap flags. The scheduler instantiates it.

Test Plan:
- W=4,H=4, in_valid=1, out_ready=1, data=row*16+col -> 8 columns. First column (col 0, row 2) is top=0x00, mid=0x10, bot=0x20. Last column is top=0x13, mid=0x23, bot=0x33 with eof=1; done pulses one cycle later.
- W=5,H=6 -> wen rotates RAM0,1,2,0,1,2 per row; column at row 5 has top_sel=0, mid_sel=1; 20 outputs total.
- out_ready low 3 cycles mid-row (W=8,H=3) -> in_ready=0, outputs and RAM enables stable; no column lost or duplicated; 8 outputs.
- start with W=2 or H=2 -> cfg_err pulse, busy stays 0, no RAM enables; start while busy -> ignored.
- rst_n asserted mid-RUN -> all outputs 0 asynchronously; new start works with wr_sel=0.
- LB_ABORT_EN: abort at row 3 of W=4,H=6 -> IDLE next cycle, no done; the following frame runs correctly.
